// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory port between instruction fetch and MEM-stage
// load/store traffic using a fixed four-state transaction with fetch anti-starvation.
module mem_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_done_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [3:0]        d_be_i,
  input  logic [31:0]       d_wdata_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_done_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                store_q, store_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;

  logic grantData;
  logic grantFetch;
  logic unusedAddrBits;

  // Data normally wins; once the streak hits the limit a waiting fetch goes first.
  assign grantData  = (state_q == IDLE) && d_req_i && (!if_req_i || (streak_q != STREAK_MAX));
  assign grantFetch = (state_q == IDLE) && if_req_i && !grantData;

  assign unusedAddrBits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                            d_addr_i[31:ADDR_W+2], d_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      store_q     <= 1'b0;
      streak_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      streak_q    <= streak_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  // Memory strobes are computed one state early so the registered outputs line up with ISSUE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    streak_d    = streak_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grantData) begin
          state_d    = ISSUE;
          owner_d    = OWN_DATA;
          store_d    = d_we_i;
          mem_addr_d = d_addr_i[ADDR_W+1:2];
          mem_we_d   = d_we_i;
          mem_be_d   = d_we_i ? d_be_i : 4'b1111;
          if (d_we_i) begin
            mem_wdata_d = d_wdata_i;
          end
          if (!if_req_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grantFetch) begin
          state_d    = ISSUE;
          owner_d    = OWN_FETCH;
          store_d    = 1'b0;
          mem_addr_d = if_addr_i[ADDR_W+1:2];
          mem_be_d   = 4'b1111;
          streak_d   = '0;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = DONE;
        if (owner_q == OWN_DATA) begin
          d_done_d = 1'b1;
          if (!store_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end else begin
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata_o    = if_rdata_q;
  assign if_done_o     = if_done_q;
  assign d_rdata_o     = d_rdata_q;
  assign d_done_o      = d_done_q;
  assign mem_address_o = mem_addr_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 64-word byte-enabled memory model
// returning read data one cycle after the address is presented.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq, dReq, dWe;
  logic [31:0] ifAddr, dAddr, dWdata;
  logic [3:0]  dBe;
  logic [31:0] ifRdata, dRdata, memWdata, memRdata;
  logic        ifDone, dDone, memWe, busy;
  logic [5:0]  memAddress;
  logic [3:0]  memBe;

  logic [31:0] memArr [64];
  int vectorCount = 0;
  int missCount   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(6), .STARVE_MAX(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_rdata_o(ifRdata), .if_done_o(ifDone),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_be_i(dBe), .d_wdata_i(dWdata),
    .d_rdata_o(dRdata), .d_done_o(dDone),
    .mem_address_o(memAddress), .mem_we_o(memWe), .mem_be_o(memBe),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata), .busy_o(busy)
  );

  // Memory model: byte-enabled write on the strobe, registered read every cycle.
  always @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (memBe[b]) memArr[memAddress][b*8 +: 8] <= memWdata[b*8 +: 8];
      end
    end
    memRdata <= memArr[memAddress];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fetch, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata);
    if (fetch) begin
      ifReq  = 1'b1;
      ifAddr = addr;
    end else begin
      dReq   = 1'b1;
      dWe    = we;
      dAddr  = addr;
      dBe    = be;
      dWdata = wdata;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int doneCount;
    int lastCycle;
    for (int i = 0; i < 64; i++) memArr[i] = 32'h1000_0000 + i;
    memArr[2]  = 32'h1122_3344;
    memArr[3]  = 32'hCAFE_0003;
    memArr[5]  = 32'hDEAD_BEEF;
    memArr[63] = 32'h600D_F00D;
    reset = 1'b1; ifReq = 0; dReq = 0; dWe = 0;
    ifAddr = 0; dAddr = 0; dBe = 0; dWdata = 0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstMemWe", {31'b0, memWe}, 32'd0);
    checkOutput("rstMemBe", {28'b0, memBe}, 32'd0);
    checkOutput("rstMemAddr", {26'b0, memAddress}, 32'd0);
    checkOutput("rstDRdata", dRdata, 32'd0);
    checkOutput("rstIfRdata", ifRdata, 32'd0);
    checkOutput("rstDones", {30'b0, ifDone, dDone}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Load from byte 0x14 -> word 5
    applyStimulus(1'b0, 1'b0, 32'h0000_0014, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("ldC1Addr", {26'b0, memAddress}, 32'd5);
    checkOutput("ldC1Be", {28'b0, memBe}, 32'hF);
    checkOutput("ldC1We", {31'b0, memWe}, 32'd0);
    checkOutput("ldC1Busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("ldC2Be", {28'b0, memBe}, 32'd0);
    checkOutput("ldC2Done", {31'b0, dDone}, 32'd0);
    @(negedge clk);
    checkOutput("ldC3Done", {31'b0, dDone}, 32'd1);
    checkOutput("ldC3Data", dRdata, 32'hDEAD_BEEF);
    checkOutput("ldC3IfDone", {31'b0, ifDone}, 32'd0);
    dReq = 1'b0;
    @(negedge clk);
    checkOutput("ldC4Done", {31'b0, dDone}, 32'd0);
    checkOutput("ldC4Busy", {31'b0, busy}, 32'd0);

    // Store byte lane 1 of word 2
    applyStimulus(1'b0, 1'b1, 32'h0000_0009, 4'b0010, 32'h0000_AB00);
    @(negedge clk);
    checkOutput("stC1We", {31'b0, memWe}, 32'd1);
    checkOutput("stC1Addr", {26'b0, memAddress}, 32'd2);
    checkOutput("stC1Be", {28'b0, memBe}, 32'b0010);
    checkOutput("stC1Wdata", memWdata, 32'h0000_AB00);
    @(negedge clk);
    checkOutput("stC2We", {31'b0, memWe}, 32'd0);
    checkOutput("stC2Done", {31'b0, dDone}, 32'd0);
    @(negedge clk);
    checkOutput("stC3We", {31'b0, memWe}, 32'd0);
    checkOutput("stC3Done", {31'b0, dDone}, 32'd1);
    checkOutput("stC3Rdata", dRdata, 32'hDEAD_BEEF);
    checkOutput("stMemWord", memArr[2], 32'h1122_AB44);
    dReq = 1'b0;
    @(negedge clk);

    // Store with no byte enables still strobes the port
    applyStimulus(1'b0, 1'b1, 32'h0000_000C, 4'b0000, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("be0We", {31'b0, memWe}, 32'd1);
    checkOutput("be0Be", {28'b0, memBe}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("be0Done", {31'b0, dDone}, 32'd1);
    checkOutput("be0MemWord", memArr[3], 32'hCAFE_0003);
    dReq = 1'b0;
    @(negedge clk);

    // Fetch alone from the top word
    applyStimulus(1'b1, 1'b0, 32'h0000_00FC, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("ifC1Busy", {31'b0, busy}, 32'd1);
    checkOutput("ifC1Addr", {26'b0, memAddress}, 32'd63);
    checkOutput("ifC1We", {31'b0, memWe}, 32'd0);
    @(negedge clk);
    checkOutput("ifC2Busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("ifC3Busy", {31'b0, busy}, 32'd1);
    checkOutput("ifC3Done", {31'b0, ifDone}, 32'd1);
    checkOutput("ifC3Data", ifRdata, 32'h600D_F00D);
    checkOutput("ifC3DDone", {31'b0, dDone}, 32'd0);
    ifReq = 1'b0;
    @(negedge clk);
    checkOutput("ifC4Busy", {31'b0, busy}, 32'd0);

    // Both requesters held: fetch gets every fifth slot
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0014, 4'h0, 32'h0);
    doneCount = 0;
    lastCycle = 0;
    for (int cyc = 0; cyc < 80 && doneCount < 10; cyc++) begin
      @(negedge clk);
      if (ifDone || dDone) begin
        checkOutput($sformatf("order%0d", doneCount), {31'b0, ifDone},
                    {31'b0, (doneCount == 4 || doneCount == 9)});
        if (doneCount > 0) checkOutput($sformatf("gap%0d", doneCount), 32'(cyc - lastCycle), 32'd4);
        lastCycle = cyc;
        doneCount++;
      end
    end
    checkOutput("starveCount", 32'(doneCount), 32'd10);
    checkOutput("starveIfData", ifRdata, 32'h1000_0000);
    checkOutput("starveDData", dRdata, 32'hDEAD_BEEF);
    ifReq = 1'b0;
    dReq  = 1'b0;
    @(negedge clk);

    // Reset during RESP of a load aborts it
    applyStimulus(1'b0, 1'b0, 32'h0000_000C, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dReq  = 1'b0;
    @(negedge clk);
    checkOutput("abtDone", {31'b0, dDone}, 32'd0);
    checkOutput("abtRdata", dRdata, 32'd0);
    checkOutput("abtWeBe", {27'b0, memWe, memBe}, 32'd0);
    checkOutput("abtBusy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abtDone2", {31'b0, dDone}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_000C, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("postRstDone", {31'b0, dDone}, 32'd1);
    checkOutput("postRstData", dRdata, 32'hCAFE_0003);
    dReq = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
